act_fetch_controller: RTL and testbench
=======================================

ACT_FETCH_CONTROLLER -- requirements
Module: act_fetch_controller

Interface
REQ-001 Parameter IO_DATA_WIDTH, default 8, width of one activation element.
REQ-002 Parameter MEM_BW, default 128, width of one activation memory word.
REQ-003 Parameter ADDR_WIDTH, default 16, activation memory word-address width.
REQ-004 Parameter CNT_WIDTH, default 16, width of the word-count field.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port arst_n_in  input  1  reset, asynchronous and active-low.
REQ-007 Port start  input  1  one-cycle request to begin a transfer; honoured only in IDLE.
REQ-008 Port base_addr  input  ADDR_WIDTH  first word address, sampled with start.
REQ-009 Port num_words  input  CNT_WIDTH  words to transfer, sampled with start.
REQ-010 Port mem_re  output  1  activation memory read enable.
REQ-011 Port mem_addr  output  ADDR_WIDTH  activation memory read address.
REQ-012 Port mem_rdata  input  MEM_BW  read data, valid exactly one cycle after mem_re.
REQ-013 Port act_word  output  MEM_BW  word presented to the activation driver (element 0 in MSBs).
REQ-014 Port act_valid  output  1  act_word holds a valid word.
REQ-015 Port act_ready  input  1  consumer accepts act_word; transfer when act_valid and act_ready high.
REQ-016 Port busy  output  1  high in every state except IDLE.
REQ-017 Port done  output  1  one-cycle pulse when the last word of a transfer is accepted.

Function
REQ-018 States IDLE, FETCH, DRAIN; one-hot or binary encoding is free.
REQ-019 IDLE + start + num_words>0 -> FETCH next cycle; address pointer := base_addr, issue counter := num_words, deliver counter := num_words.
REQ-020 IDLE + start + num_words==0 -> stay IDLE, done pulses next cycle, no mem_re issued.
REQ-021 start while busy is ignored; no latched value changes.
REQ-022 FETCH: mem_re high in a cycle iff issue counter >0 and (words in buffer + reads in flight) < 2; mem_addr = address pointer in that cycle.
REQ-023 Each issued read: address pointer +1 modulo 2^ADDR_WIDTH (wrap 2^ADDR_WIDTH-1 -> 0), issue counter -1.
REQ-024 FETCH -> DRAIN in the cycle after issue counter reaches 0.
REQ-025 mem_rdata is written into a 2-entry FIFO one cycle after its mem_re; the credit rule of REQ-022 guarantees no overflow; overflow is a design error flagged by an assertion.
REQ-026 act_valid = FIFO not empty; act_word = FIFO head; word order equals address order.
REQ-027 Simultaneous FIFO write and pop in one cycle is legal at any fill level and keeps the count unchanged.
REQ-028 Each accepted word decrements deliver counter; when it reaches 0: done pulses in that same cycle (combinational from final handshake) and state -> IDLE next cycle.
REQ-029 act_valid held high with act_word stable until accepted (no retraction).
REQ-030 Throughput: with act_ready constantly high, one word per cycle after a 2-cycle start-up latency (start -> first act_valid).
REQ-031 mem_addr = 0 whenever mem_re is low.

Reset
REQ-032 Assertion of arst_n_in, at any time including mid-transfer, immediately forces state IDLE, FIFO empty, counters and pointer 0.
REQ-033 Reset values: mem_re 0, mem_addr 0, act_word 0, act_valid 0, busy 0, done 0.
REQ-034 Read data returning in the first cycle after deassertion is discarded.

Structure
REQ-035 State enumeration type and default parameters (IO_DATA_WIDTH, MEM_BW, ADDR_WIDTH) live in the shared accelerator package.
REQ-036 The 2-entry buffer is sub-module act_word_fifo (parameter WIDTH, ports clk, arst_n_in, push, pop, din, dout, empty, full).
REQ-037 Implementation size 120-400 lines of RTL including the sub-module.

Verification
REQ-038 start, base_addr=0x0010, num_words=4, act_ready=1 -> mem_addr 0x10..0x13 on consecutive cycles, act_word=mem[0x10..0x13] in order, done once, busy low after.
REQ-039 base_addr=0xFFFE, num_words=4 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-040 num_words=5, act_ready low for 6 cycles mid-transfer -> at most 2 words buffered, mem_re stalls, act_word stable, no word lost or duplicated.
REQ-041 num_words=0 -> no mem_re, done pulses one cycle after start, busy stays 0.
REQ-042 start pulsed again during transfer of 8 words -> ignored; exactly 8 words delivered.
REQ-043 arst_n_in asserted after 3 of 8 words -> all outputs 0 asynchronously; new start with num_words=2 then completes correctly.

Source files
------------

// File: rtl/act_fetch_controller_pkg.sv
// Shared accelerator definitions: default widths and the fetch controller state type.
package act_fetch_controller_pkg;

  localparam int ACT_IO_DATA_WIDTH = 8;
  localparam int ACT_MEM_BW        = 128;
  localparam int ACT_ADDR_WIDTH    = 16;
  localparam int ACT_CNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // Occupancy (0..2) of a two-entry buffer from its flags.
  function automatic logic [1:0] fill_level(input logic empty, input logic full);
    if (full)       return 2'd2;
    else if (empty) return 2'd0;
    else            return 2'd1;
  endfunction

endpackage

// File: rtl/act_word_fifo.sv
// Two-entry word buffer between the activation memory and the activation driver.
module act_word_fifo #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  // A pop frees its slot in the same cycle, so push+pop is accepted even when full.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

  a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n_in)
    !(push && full && !pop));

endmodule

// File: rtl/act_fetch_controller.sv
// Streams num_words activation words from memory at base_addr into a valid/ready consumer.
module act_fetch_controller
  import act_fetch_controller_pkg::*;
#(
  parameter int IO_DATA_WIDTH = ACT_IO_DATA_WIDTH,
  parameter int MEM_BW        = ACT_MEM_BW,
  parameter int ADDR_WIDTH    = ACT_ADDR_WIDTH,
  parameter int CNT_WIDTH     = ACT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_BW-1:0]     mem_rdata,
  output logic [MEM_BW-1:0]     act_word,
  output logic                  act_valid,
  input  logic                  act_ready,
  output logic                  busy,
  output logic                  done,
  output fetch_state_t          state_dbg
);

  // Handshake: a word moves when act_valid && act_ready on a rising edge; once
  // raised, act_valid stays high and act_word stays stable until that happens.

  if (MEM_BW % IO_DATA_WIDTH != 0) begin : g_width_check
    $error("MEM_BW must be a whole number of IO_DATA_WIDTH elements");
  end

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] addr_ptr;
  logic [CNT_WIDTH-1:0]  issue_cnt;
  logic [CNT_WIDTH-1:0]  deliver_cnt;
  logic                  inflight;
  logic                  done_zero;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop_fire;
  logic                  last_accept;
  logic [2:0]            occupancy;

  act_word_fifo #(
    .WIDTH (MEM_BW)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .push      (inflight),
    .pop       (pop_fire),
    .din       (mem_rdata),
    .dout      (act_word),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign act_valid   = !fifo_empty;
  assign pop_fire    = act_valid && act_ready;
  assign last_accept = pop_fire && (deliver_cnt == CNT_WIDTH'(1));

  // Credit counts buffered words that survive this cycle plus the read in flight,
  // so a word leaving in the same cycle lets a new read issue back-to-back.
  assign occupancy = 3'(fill_level(fifo_empty, fifo_full)) + 3'(inflight) - 3'(pop_fire);
  assign mem_re    = (state == ST_FETCH) && (issue_cnt != '0) && (occupancy < 3'd2);
  assign mem_addr  = mem_re ? addr_ptr : '0;

  assign busy      = (state != ST_IDLE);
  assign done      = last_accept || done_zero;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state       <= ST_IDLE;
      addr_ptr    <= '0;
      issue_cnt   <= '0;
      deliver_cnt <= '0;
      inflight    <= 1'b0;
      done_zero   <= 1'b0;
    end else begin
      done_zero <= 1'b0;
      inflight  <= mem_re;
      if (mem_re) begin
        addr_ptr  <= addr_ptr + ADDR_WIDTH'(1);
        issue_cnt <= issue_cnt - CNT_WIDTH'(1);
      end
      if (pop_fire) deliver_cnt <= deliver_cnt - CNT_WIDTH'(1);

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              state       <= ST_FETCH;
              addr_ptr    <= base_addr;
              issue_cnt   <= num_words;
              deliver_cnt <= num_words;
            end else begin
              done_zero <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (last_accept)           state <= ST_IDLE;
          else if (issue_cnt == '0)  state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (last_accept) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_fetch_controller.sv
// Bench for act_fetch_controller: memory responder, monitor-side scoreboard and directed/random transfers.
module tb_act_fetch_controller;
  import act_fetch_controller_pkg::*;

  localparam int MEM_BW = 128;
  localparam int AW     = 16;
  localparam int CW     = 16;

  logic              clk = 1'b0;
  logic              arst_n_in;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [CW-1:0]     num_words;
  logic              mem_re;
  logic [AW-1:0]     mem_addr;
  logic [MEM_BW-1:0] mem_rdata;
  logic [MEM_BW-1:0] act_word;
  logic              act_valid;
  logic              act_ready;
  logic              busy;
  logic              done;
  fetch_state_t      state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [MEM_BW-1:0] exp_q[$];
  logic [AW-1:0]     exp_addr_q[$];
  int                outstanding = 0;
  int                done_total  = 0;
  int                acc_total   = 0;
  int                done_cyc    = 0;
  int                first_valid_cyc = 0;
  bit                seen_valid  = 0;
  bit                prev_stall  = 0;
  logic [MEM_BW-1:0] prev_word   = '0;

  act_fetch_controller dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .act_word  (act_word),
    .act_valid (act_valid),
    .act_ready (act_ready),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [MEM_BW-1:0] mem_word(input logic [AW-1:0] a);
    return {4{a, a ^ 16'hC3A5}};
  endfunction

  // Memory answers one cycle after mem_re; otherwise returns junk.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem_word(mem_addr);
    else        mem_rdata <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic check(input string tag, input logic [MEM_BW-1:0] got, input logic [MEM_BW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard / monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (arst_n_in) begin
      int pop_now;
      pop_now = (act_valid && act_ready) ? 1 : 0;
      if (prev_stall) begin
        check("hold_valid", act_valid, 1'b1);
        check("hold_word", act_word, prev_word);
      end
      prev_stall = act_valid && !act_ready;
      prev_word  = act_word;
      if (act_valid && !seen_valid) begin
        seen_valid      = 1;
        first_valid_cyc = cyc;
      end
      if (act_valid && act_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", act_valid, 1'b0);
        else check("act_word", act_word, exp_q.pop_front());
        acc_total++;
      end
      if (mem_re) begin
        if (exp_addr_q.size() == 0) check("re_unexpected", mem_re, 1'b0);
        else check("mem_addr", mem_addr, exp_addr_q.pop_front());
        check("credit_le_2", ((outstanding - pop_now) <= 1) ? 1'b1 : 1'b0, 1'b1);
        outstanding++;
      end else begin
        check("addr_idle_zero", mem_addr, '0);
      end
      outstanding -= pop_now;
      if (done) begin
        done_total++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      default: return !(c >= 4 && c < 10);
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_re"},    mem_re,    1'b0);
    check({tag, "_mem_addr"},  mem_addr,  '0);
    check({tag, "_act_word"},  act_word,  '0);
    check({tag, "_act_valid"}, act_valid, 1'b0);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_done"},      done,      1'b0);
    check({tag, "_state"},     state_dbg, ST_IDLE);
  endtask

  // Expected stream: words base, base+1, ... modulo 2^AW, in order.
  task automatic load_expect(input logic [AW-1:0] base, input logic [CW-1:0] n);
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(base + AW'(i));
      exp_q.push_back(mem_word(base + AW'(i)));
    end
  endtask

  task automatic run_txn(input logic [AW-1:0] base, input logic [CW-1:0] n,
                         input int mode, input int restart_at);
    int done_before;
    int start_cyc;
    done_before = done_total;
    seen_valid  = 0;
    load_expect(base, n);
    @(posedge clk); #1;
    base_addr = base; num_words = n; start = 1'b1;
    act_ready = ready_for(mode, 0);
    start_cyc = cyc;
    for (int c = 1; c < 400; c++) begin
      @(posedge clk); #1;
      start = (c == restart_at);
      if (c == restart_at) begin
        base_addr = 16'hAAAA;
        num_words = 16'd3;
      end
      act_ready = ready_for(mode, c);
      if (done_total != done_before) break;
    end
    start = 1'b0;
    act_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("done_once", done_total - done_before, 1);
    check("busy_after", busy, 1'b0);
    check("state_after", state_dbg, ST_IDLE);
    check("words_left", exp_q.size(), 0);
    check("addrs_left", exp_addr_q.size(), 0);
    if (mode == 0) begin
      // Latency counted from the edge that samples start.
      check("latency", first_valid_cyc - (start_cyc + 1), 2);
      check("throughput", done_cyc - first_valid_cyc, int'(n) - 1);
    end
  endtask

  initial begin
    int done_before;
    int acc_before;
    arst_n_in = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    act_ready = 1'b1;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 arst_n_in = 1'b1;

    run_txn(16'h0010, 16'd4, 0, -1);
    run_txn(16'hFFFE, 16'd4, 0, -1);
    run_txn(16'h0100, 16'd5, 2, -1);
    run_txn(16'h0200, 16'd8, 0, 3);

    // Zero-length request: no read, done one cycle later, never busy.
    done_before = done_total;
    @(posedge clk); #1;
    base_addr = 16'h0300; num_words = '0; start = 1'b1;
    @(negedge clk);
    check("zero_done_early", done, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    @(negedge clk);
    check("zero_done_clear", done, 1'b0);
    check("zero_done_count", done_total - done_before, 1);

    // Reset after three of eight words, then a fresh two-word transfer.
    acc_before = acc_total;
    load_expect(16'h0500, 16'd8);
    @(posedge clk); #1;
    base_addr = 16'h0500; num_words = 16'd8; start = 1'b1; act_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (acc_total - acc_before >= 3) break;
    end
    check("pre_reset_accepted", acc_total - acc_before, 3);
    check("pre_reset_busy", busy, 1'b1);
    #2 arst_n_in = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_addr_q.delete();
    outstanding = 0;
    prev_stall  = 0;
    repeat (2) @(posedge clk);
    #1 arst_n_in = 1'b1;
    run_txn(16'h0040, 16'd2, 0, -1);

    // Randomised transfers with random backpressure.
    for (int k = 0; k < 10; k++) begin
      logic [AW-1:0] b;
      logic [CW-1:0] n;
      b = AW'($urandom);
      n = CW'($urandom_range(1, 12));
      run_txn(b, n, 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
